branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- EX-stage branch resolution block; sits directly downstream of the branch predictor.
- Latches each ID-stage branch together with its prediction into an ID/EX holding register.
- Compares the prediction against the actual condition computed in EX.
- Feeds the resolved outcome back to the predictor, and raises flush/redirect on a mispredict.
- A small FSM squashes wrong-path capture during recovery.

Parameters:
- PC_W, 32, width of PC and target values.
- RECOVER_CYCLES, 1, cycles spent in RECOVER after a mispredict (legal range 1..15).
- STAT_W, 32, width of statistics counters (optional feature only).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall_ID  in  1  ID stage stalled; inserts a bubble into EX.
- BranchInstructExists_ID  in  1  branch instruction present in ID.
- Prediction_ID  in  1  predictor output for the ID branch (1 = taken).
- PCPlus4_ID  in  PC_W  fall-through address of the ID branch.
- BranchTarget_ID  in  PC_W  taken target of the ID branch.
- ConditionMet_EX  in  1  actual branch condition evaluated in EX.
- BranchInstructExists_EX  out  1  resolved branch present in EX (to predictor).
- BranchDecision_EX  out  1  actual outcome (to predictor).
- Mispredict  out  1  prediction differs from outcome.
- Flush_IF_ID  out  1  squash IF/ID register.
- Flush_ID_EX  out  1  squash ID/EX register.
- RedirectValid  out  1  fetch must redirect this cycle.
- RedirectPC  out  PC_W  corrected fetch address.
- BranchCount  out  STAT_W  resolved-branch count (optional feature).
- MispredictCount  out  STAT_W  mispredict count (optional feature).

Behaviour:
- Holding register fields: Valid_q, Pred_q, PCPlus4_q, Target_q.
- FSM states: NORMAL, RECOVER. A 4-bit RecoverCnt runs while in RECOVER.
- Capture rule, evaluated each edge: Valid_q <= BranchInstructExists_ID & ~Stall_ID & ~Mispredict & (state==NORMAL).
  - Pred_q, PCPlus4_q and Target_q load whenever the capture condition is true; otherwise they hold.
- Combinational outputs from the register:
  - BranchInstructExists_EX = Valid_q.
  - BranchDecision_EX = Valid_q & ConditionMet_EX.
  - Mispredict = Valid_q & (Pred_q ^ ConditionMet_EX).
  - RedirectValid = Flush_IF_ID = Flush_ID_EX = Mispredict.
  - RedirectPC = ConditionMet_EX ? Target_q : PCPlus4_q when Mispredict; 0 otherwise.
- Latency: a branch sampled in ID at edge t is resolved, with flush/redirect asserted, during cycle t+1. Resolution is exactly one cycle.
- Stall_ID=1: EX receives a bubble (Valid_q=0). The ID branch is held upstream and captured on the first unstalled edge.
- Mispredict in the same cycle as a new ID branch: the ID branch is wrong-path and is discarded (Valid_q<=0).
- Back-to-back branches: Valid_q stays high on consecutive cycles. Each cycle is one independent resolution and one pulse to the predictor.
- FSM transitions:
  - NORMAL -> RECOVER on Mispredict; RecoverCnt <= RECOVER_CYCLES-1.
  - RECOVER: no capture. RecoverCnt decrements each cycle; return to NORMAL on the edge where RecoverCnt==0.
  - Mispredict cannot occur in RECOVER, since Valid_q is 0.
- Reset (at any time, including mid-resolution):
  - Valid_q, Pred_q and the PCs go to 0; state goes to NORMAL; RecoverCnt goes to 0.
  - All outputs read 0 in the cycle after reset.
  - An in-flight branch is dropped with no redirect.
- RECOVER_CYCLES outside 1..15 is a configuration error, flagged by an elaboration check.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - BranchCount increments on each cycle with Valid_q=1.
  - MispredictCount increments on each Mispredict.
  - Both saturate at all-ones and clear on Reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Decomposition:
- Shared package branch_pkg holds:
  - the state typedef (NORMAL, RECOVER);
  - PC_W_DEF = 32 and STAT_W_DEF = 32;
  - RECOVER_CNT_W = 4.
- One natural sub-module: branch_sat_counter, a parameterised-width saturating counter with sync reset and enable. It is instantiated twice under BRANCH_STATS_EN.

Test Plan:
- Correct prediction: ID branch, Prediction_ID=1, Target=0x100, PCPlus4=0x44; next cycle ConditionMet_EX=1 -> BranchInstructExists_EX=1, BranchDecision_EX=1, Mispredict=0, RedirectValid=0.
- Mispredict not-taken: Prediction_ID=0, Target=0x200, PCPlus4=0x80; next cycle ConditionMet_EX=1 -> Mispredict=1, Flush_IF_ID=Flush_ID_EX=1, RedirectPC=0x200. A simultaneous ID branch is not captured; the FSM spends 1 cycle in RECOVER.
- Mispredict taken: Prediction_ID=1, PCPlus4=0x84; ConditionMet_EX=0 -> RedirectPC=0x84, BranchDecision_EX=0.
- Stall: BranchInstructExists_ID=1 with Stall_ID=1 for 2 cycles, then 0 -> BranchInstructExists_EX stays 0 for 2 cycles, then is high exactly 1 cycle.
- Reset mid-operation: assert Reset in the cycle Valid_q=1 with a pending mispredict -> next cycle all outputs 0, state NORMAL, no redirect.
- BRANCH_STATS_EN: 5 branches with 2 mispredicts -> BranchCount=5, MispredictCount=2. With STAT_W=2 and 5 branches -> BranchCount saturates at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution slice.
// Holds the recovery FSM state type, default widths and the width of the
// recovery countdown counter.
package branch_pkg;

  // Recovery FSM states
  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } brState_t;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned STAT_W_DEF    = 32;
  localparam int unsigned RECOVER_CNT_W = 4;

endpackage

// File: rtl/branch_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and enable.
// Ports:
//   Clock  - system clock
//   Reset  - synchronous, active-high clear
//   Enable - count up by one this edge (holds once all-ones)
//   Count  - current count value
module branch_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Enable,
  output logic [W-1:0] Count
);

  // Stop at all-ones so a long run never wraps to a small value
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count <= '0;
    end else if (Enable && (Count != {W{1'b1}})) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution unit.
// Captures the ID-stage branch and its prediction into an ID/EX holding
// register, compares the prediction with the EX condition, reports the
// outcome to the predictor and raises flush/redirect on a mispredict.
// A small NORMAL/RECOVER FSM blocks wrong-path capture after a mispredict.
//
// Optional feature: define BRANCH_STATS_EN to build saturating resolved-branch
// and mispredict counters; otherwise BranchCount/MispredictCount read 0.
//
// Ports:
//   Clock, Reset                 - clock, synchronous active-high reset
//   Stall_ID                     - ID stalled, EX receives a bubble
//   BranchInstructExists_ID      - branch present in ID
//   Prediction_ID                - predicted direction (1 = taken)
//   PCPlus4_ID, BranchTarget_ID  - fall-through and taken addresses
//   ConditionMet_EX              - actual condition evaluated in EX
//   BranchInstructExists_EX      - resolved branch present (to predictor)
//   BranchDecision_EX            - actual outcome (to predictor)
//   Mispredict                   - prediction differs from outcome
//   Flush_IF_ID, Flush_ID_EX     - squash the front-end pipeline registers
//   RedirectValid, RedirectPC    - corrected fetch request
//   BranchCount, MispredictCount - statistics (optional feature)
module branch_resolve_unit import branch_pkg::*; #(
  parameter int unsigned PC_W           = PC_W_DEF,
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned STAT_W         = STAT_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall_ID,
  input  logic              BranchInstructExists_ID,
  input  logic              Prediction_ID,
  input  logic [PC_W-1:0]   PCPlus4_ID,
  input  logic [PC_W-1:0]   BranchTarget_ID,
  input  logic              ConditionMet_EX,
  output logic              BranchInstructExists_EX,
  output logic              BranchDecision_EX,
  output logic              Mispredict,
  output logic              Flush_IF_ID,
  output logic              Flush_ID_EX,
  output logic              RedirectValid,
  output logic [PC_W-1:0]   RedirectPC,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] MispredictCount
);

  // Recovery length must fit the 4-bit countdown and be at least one cycle
  if ((RECOVER_CYCLES < 1) || (RECOVER_CYCLES > 15)) begin : gRecoverCyclesCheck
    $error("branch_resolve_unit: RECOVER_CYCLES must be within 1..15");
  end

  // ID/EX holding register
  logic            valid_q;
  logic            pred_q;
  logic [PC_W-1:0] pcPlus4_q;
  logic [PC_W-1:0] target_q;

  brState_t                 state;
  logic [RECOVER_CNT_W-1:0] recoverCnt;

  logic mispredictC;
  logic captureC;

  // Resolution is purely a function of the held branch and the EX condition
  assign mispredictC = valid_q & (pred_q ^ ConditionMet_EX);

  // A branch arriving alongside a mispredict, or during recovery, is wrong-path
  assign captureC = BranchInstructExists_ID & ~Stall_ID & ~mispredictC &
                    (state == NORMAL);

  assign BranchInstructExists_EX = valid_q;
  assign BranchDecision_EX       = valid_q & ConditionMet_EX;
  assign Mispredict              = mispredictC;
  assign Flush_IF_ID             = mispredictC;
  assign Flush_ID_EX             = mispredictC;
  assign RedirectValid           = mispredictC;
  assign RedirectPC              = mispredictC ? (ConditionMet_EX ? target_q : pcPlus4_q)
                                               : '0;

  // Holding register; payload fields hold when nothing is captured
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q   <= 1'b0;
      pred_q    <= 1'b0;
      pcPlus4_q <= '0;
      target_q  <= '0;
    end else begin
      valid_q <= captureC;
      if (captureC) begin
        pred_q    <= Prediction_ID;
        pcPlus4_q <= PCPlus4_ID;
        target_q  <= BranchTarget_ID;
      end
    end
  end

  // Recovery FSM: RECOVER lasts RECOVER_CYCLES cycles after a mispredict
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= NORMAL;
      recoverCnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (mispredictC) begin
            state      <= RECOVER;
            recoverCnt <= RECOVER_CNT_W'(RECOVER_CYCLES - 1);
          end
        end
        RECOVER: begin
          if (recoverCnt == '0) begin
            state <= NORMAL;
          end else begin
            recoverCnt <= recoverCnt - RECOVER_CNT_W'(1);
          end
        end
        default: begin
          state      <= NORMAL;
          recoverCnt <= '0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Every valid EX cycle is one resolved branch
  branch_sat_counter #(.W(STAT_W)) uBranchCounter (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (valid_q),
    .Count  (BranchCount)
  );

  branch_sat_counter #(.W(STAT_W)) uMispredictCounter (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (mispredictC),
    .Count  (MispredictCount)
  );
`else
  assign BranchCount     = '0;
  assign MispredictCount = '0;
`endif

endmodule
